seq_digit_gen: RTL and testbench

- Parametrised digit-sequence generator; successor to the fixed 4-bit date-digit counter.
- Steps through a programmable table of DEPTH digits, each WIDTH bits wide, one entry per enabled clock.
- Runtime-writable table, forward/reverse direction, wrap or one-shot mode, and wrap/done status.
- Drives display/digit consumers in the same designs as the fixed counter.

---
 rtl/seq_digit_gen.sv | 103 ++++++++++
 tb/tb_seq_digit_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seq_digit_gen.sv
// Programmable digit-sequence generator: walks a writable table of DEPTH digits,
// forward or reverse, wrapping or stopping at the end, with wrap/done status.
module seq_digit_gen #(
  parameter int                       WIDTH = 4,
  parameter int                       DEPTH = 6,
  parameter logic [DEPTH*WIDTH-1:0]   INIT  = {4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h9},
  localparam int                      IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             restart,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] digit,
  output logic [IW-1:0]    idx,
  output logic             wrap,
  output logic             done
);

  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  logic [WIDTH-1:0] table_reg [DEPTH];
  logic [DEPTH-1:0] wr_hit;
  logic             wr_ok;
  logic             at_bound;
  logic [IW-1:0]    start_idx;
  logic [IW-1:0]    step_idx;
  logic [IW-1:0]    idx_next;
  logic [WIDTH-1:0] digit_next;
  logic             wrap_next;
  logic             done_next;

  // Out-of-range addresses are dropped so they can never alias onto a real entry.
  assign wr_ok = wr_en && (wr_addr <= LAST);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign wr_hit[gi] = wr_ok && (wr_addr == IW'(gi));
    end
  endgenerate

  always_comb begin
    at_bound   = dir ? (idx == '0) : (idx == LAST);
    start_idx  = dir ? LAST : '0;
    step_idx   = dir ? (idx - IW'(1)) : (idx + IW'(1));
    idx_next   = idx;
    wrap_next  = 1'b0;
    done_next  = done;
    if (restart) begin
      idx_next  = start_idx;
      done_next = 1'b0;
    end else if (en && !done) begin
      if (!at_bound) begin
        idx_next = step_idx;
      end else if (mode) begin
        done_next = 1'b1;
      end else begin
        idx_next  = start_idx;
        wrap_next = 1'b1;
      end
    end
    // A same-edge write to the entry we are moving onto must show up immediately.
    if (wr_ok && (wr_addr == idx_next)) begin
      digit_next = wr_data;
    end else begin
      digit_next = table_reg[idx_next];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        table_reg[k] <= INIT[k*WIDTH +: WIDTH];
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_hit[k]) begin
          table_reg[k] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      digit <= INIT[WIDTH-1:0];
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      idx   <= idx_next;
      digit <= digit_next;
      wrap  <= wrap_next;
      done  <= done_next;
    end
  end

endmodule

// File: tb/tb_seq_digit_gen.sv
// Directed bench for seq_digit_gen: default 4x6 instance plus an 8-bit, 5-entry instance.
module tb_seq_digit_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       en = 0, dir = 0, mode = 0, restart = 0, wr_en = 0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [3:0] digit;
  logic [2:0] idx;
  logic       wrap, done;

  logic       b_en = 0;
  logic [7:0] b_digit;
  logic [2:0] b_idx;
  logic       b_wrap, b_done;

  int n_checks = 0;
  int n_errors = 0;

  int exp_a [6] = '{9, 2, 1, 2, 1, 2};
  int exp_b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  always #5 clk = ~clk;

  seq_digit_gen dut_a (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .restart(restart),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .digit(digit), .idx(idx), .wrap(wrap), .done(done)
  );

  seq_digit_gen #(.WIDTH(8), .DEPTH(5), .INIT(40'h55_44_33_22_11)) dut_b (
    .clk(clk), .reset(reset), .en(b_en), .dir(1'b0), .mode(1'b0), .restart(1'b0),
    .wr_en(1'b0), .wr_addr(3'd0), .wr_data(8'd0),
    .digit(b_digit), .idx(b_idx), .wrap(b_wrap), .done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t idx=%0d digit=%0h wrap=%0b done=%0b | b_idx=%0d b_digit=%0h b_wrap=%0b",
             $time, idx, digit, wrap, done, b_idx, b_digit, b_wrap);
  endtask

  task automatic do_reset();
    en = 0; dir = 0; mode = 0; restart = 0; wr_en = 0; b_en = 0;
    reset = 0;
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic check_a(input string tag, input int e_idx, input int e_digit,
                         input int e_wrap, input int e_done);
    check({tag, ".idx"},   32'(idx),   32'(e_idx));
    check({tag, ".digit"}, 32'(digit), 32'(e_digit));
    check({tag, ".wrap"},  32'(wrap),  32'(e_wrap));
    check({tag, ".done"},  32'(done),  32'(e_done));
  endtask

  initial begin
    // Forward wrap run with default table
    do_reset();
    check_a("reset", 0, 9, 0, 0);
    check("reset.b_digit", 32'(b_digit), 32'h11);
    en = 1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check_a($sformatf("fwd%0d", k), k % 6, exp_a[k % 6], (k == 6) ? 1 : 0, 0);
    end

    // One-shot: stops at the last entry, sets done, never wraps
    do_reset();
    mode = 1; en = 1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check_a($sformatf("os%0d", k), (k < 5) ? k : 5, exp_a[(k < 5) ? k : 5], 0, (k >= 6) ? 1 : 0);
    end
    mode = 0;
    step();
    check_a("os_mode_chg", 5, 2, 0, 1);
    restart = 1;
    step();
    restart = 0; en = 0;
    check_a("os_restart", 0, 9, 0, 0);

    // Reverse from reset: immediate wrap to the last entry
    do_reset();
    dir = 1; en = 1;
    step(); check_a("rev1", 5, 2, 1, 0);
    step(); check_a("rev2", 4, 1, 0, 0);
    step(); check_a("rev3", 3, 2, 0, 0);

    // Write forwarding onto the next index, then an out-of-range write
    do_reset();
    en = 1; wr_en = 1; wr_addr = 3'd1; wr_data = 4'hF;
    step(); check_a("fwdwr", 1, 15, 0, 0);
    en = 0; wr_addr = 3'd7; wr_data = 4'h3;
    step(); check_a("oob_hold", 1, 15, 0, 0);
    wr_en = 0; en = 1;
    for (int k = 2; k <= 7; k++) begin
      step();
      check_a($sformatf("tbl%0d", k), k % 6, (k % 6 == 1) ? 15 : exp_a[k % 6], (k == 6) ? 1 : 0, 0);
    end

    // restart beats en; then asynchronous reset mid-run
    do_reset();
    en = 1;
    step(); step(); step();
    check_a("pre_rs", 3, 2, 0, 0);
    restart = 1;
    step(); check_a("restart_en", 0, 9, 0, 0);
    restart = 0;
    step(); step(); step(); step();
    check_a("pre_async", 4, 1, 0, 0);
    #2;
    reset = 0;
    #1;
    check_a("async_rst", 0, 9, 0, 0);
    #3;
    reset = 1;
    en = 0;

    // 8-bit, 5-entry instance: wraps 4->0, never exceeds 4
    do_reset();
    b_en = 1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("b%0d.idx", k),   32'(b_idx),   32'(k % 5));
      check($sformatf("b%0d.digit", k), 32'(b_digit), 32'(exp_b[k % 5]));
      check($sformatf("b%0d.wrap", k),  32'(b_wrap),  32'((k % 5 == 0) ? 1 : 0));
      check($sformatf("b%0d.range", k), 32'(b_idx <= 3'd4), 32'd1);
    end
    check("b.done", 32'(b_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
